// File: rtl/sram_dual_fifo_ctrl.sv
// rtl/sram_dual_fifo_ctrl.sv - two independent FIFOs sharing a 4-port 256x16 SRAM
module sram_fifo_chan #(
  parameter int   DATA_WIDTH = 16,
  parameter int   ADDR_WIDTH = 8,
  parameter logic CH_SEL     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_valid,
  output logic                  push_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] count,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] r_data
);
  localparam int PW = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] FULL = ADDR_WIDTH'(1 << PW);
  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ZERO = '0;

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] count_q, avail;
  logic                  inflight;
  logic [1:0]            occ, occ_d;
  logic [DATA_WIDTH-1:0] hold0, hold1, hold0_d, hold1_d;
  logic                  push_fire, pop_fire;

  assign push_ready = (count_q != FULL);
  assign pop_valid  = (occ != 2'd0);
  assign pop_data   = hold0;
  assign count      = count_q;

  assign push_fire = rst_n & push_valid & push_ready & ~flush;
  assign pop_fire  = rst_n & pop_valid & pop_ready & ~flush;

  // occ_d already credits a pop in this cycle, so the next read can issue
  // while the head is being consumed and the stream keeps one word per cycle.
  assign occ_d = occ + {1'b0, inflight} - {1'b0, pop_fire};
  assign r_en  = rst_n & ~flush & (avail != ZERO) & (occ_d < 2'd2);

  assign w_en   = push_fire;
  assign w_addr = push_fire ? {CH_SEL, wr_ptr} : ZERO;
  assign w_data = push_fire ? push_data : '0;
  assign r_addr = r_en ? {CH_SEL, rd_ptr} : ZERO;

  always_comb begin
    hold0_d = hold0;
    hold1_d = hold1;
    case ({pop_fire, inflight})
      2'b01: begin
        if (occ == 2'd0) hold0_d = r_data;
        else             hold1_d = r_data;
      end
      2'b10: hold0_d = hold1;
      2'b11: begin
        if (occ == 2'd1) begin
          hold0_d = r_data;
        end else begin
          hold0_d = hold1;
          hold1_d = r_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      avail    <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      hold0    <= '0;
      hold1    <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      avail    <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      hold0    <= '0;
      hold1    <= '0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(push_fire);
      rd_ptr   <= rd_ptr + PW'(r_en);
      count_q  <= count_q + (push_fire ? ONE : ZERO) - (pop_fire ? ONE : ZERO);
      avail    <= avail + (push_fire ? ONE : ZERO) - (r_en ? ONE : ZERO);
      inflight <= r_en;
      occ      <= occ_d;
      hold0    <= hold0_d;
      hold1    <= hold1_d;
    end
  end
endmodule

module sram_dual_fifo_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Ch0_Push_Data_In,
  input  logic                  Ch0_Push_Valid_In,
  output logic                  Ch0_Push_Ready_Out,
  output logic [DATA_WIDTH-1:0] Ch0_Pop_Data_Out,
  output logic                  Ch0_Pop_Valid_Out,
  input  logic                  Ch0_Pop_Ready_In,
  input  logic                  Ch0_Flush_In,
  output logic [ADDR_WIDTH-1:0] Ch0_Count_Out,
  input  logic [DATA_WIDTH-1:0] Ch1_Push_Data_In,
  input  logic                  Ch1_Push_Valid_In,
  output logic                  Ch1_Push_Ready_Out,
  output logic [DATA_WIDTH-1:0] Ch1_Pop_Data_Out,
  output logic                  Ch1_Pop_Valid_Out,
  input  logic                  Ch1_Pop_Ready_In,
  input  logic                  Ch1_Flush_In,
  output logic [ADDR_WIDTH-1:0] Ch1_Count_Out,
  output logic [DATA_WIDTH-1:0] Sram_W_A_Data_Out,
  output logic [ADDR_WIDTH-1:0] Sram_W_A_Address_Out,
  output logic                  Sram_W_A_Write_Enable_Out,
  output logic [DATA_WIDTH-1:0] Sram_W_B_Data_Out,
  output logic [ADDR_WIDTH-1:0] Sram_W_B_Address_Out,
  output logic                  Sram_W_B_Write_Enable_Out,
  output logic [ADDR_WIDTH-1:0] Sram_R_C_Address_Out,
  output logic                  Sram_R_C_Read_Enable_Out,
  input  logic [DATA_WIDTH-1:0] Sram_R_C_Data_In,
  output logic [ADDR_WIDTH-1:0] Sram_R_D_Address_Out,
  output logic                  Sram_R_D_Read_Enable_Out,
  input  logic [DATA_WIDTH-1:0] Sram_R_D_Data_In
);
  sram_fifo_chan #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CH_SEL(1'b0)) u_ch0 (
    .clk        (Clk_In),
    .rst_n      (Reset_In),
    .push_data  (Ch0_Push_Data_In),
    .push_valid (Ch0_Push_Valid_In),
    .push_ready (Ch0_Push_Ready_Out),
    .pop_data   (Ch0_Pop_Data_Out),
    .pop_valid  (Ch0_Pop_Valid_Out),
    .pop_ready  (Ch0_Pop_Ready_In),
    .flush      (Ch0_Flush_In),
    .count      (Ch0_Count_Out),
    .w_data     (Sram_W_A_Data_Out),
    .w_addr     (Sram_W_A_Address_Out),
    .w_en       (Sram_W_A_Write_Enable_Out),
    .r_addr     (Sram_R_C_Address_Out),
    .r_en       (Sram_R_C_Read_Enable_Out),
    .r_data     (Sram_R_C_Data_In)
  );

  sram_fifo_chan #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .CH_SEL(1'b1)) u_ch1 (
    .clk        (Clk_In),
    .rst_n      (Reset_In),
    .push_data  (Ch1_Push_Data_In),
    .push_valid (Ch1_Push_Valid_In),
    .push_ready (Ch1_Push_Ready_Out),
    .pop_data   (Ch1_Pop_Data_Out),
    .pop_valid  (Ch1_Pop_Valid_Out),
    .pop_ready  (Ch1_Pop_Ready_In),
    .flush      (Ch1_Flush_In),
    .count      (Ch1_Count_Out),
    .w_data     (Sram_W_B_Data_Out),
    .w_addr     (Sram_W_B_Address_Out),
    .w_en       (Sram_W_B_Write_Enable_Out),
    .r_addr     (Sram_R_D_Address_Out),
    .r_en       (Sram_R_D_Read_Enable_Out),
    .r_data     (Sram_R_D_Data_In)
  );
endmodule

// File: tb/tb_sram_dual_fifo_ctrl.sv
// tb/tb_sram_dual_fifo_ctrl.sv - randomized bench for sram_dual_fifo_ctrl against a queue model
module tb_sram_dual_fifo_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] push_data [2];
  logic        push_valid [2];
  logic        pop_ready [2];
  logic        flush [2];
  logic        push_ready [2];
  logic        pop_valid [2];
  logic [15:0] pop_data [2];
  logic [7:0]  count [2];
  logic [15:0] w_data [2];
  logic [7:0]  w_addr [2];
  logic        w_en [2];
  logic [7:0]  r_addr [2];
  logic        r_en [2];
  logic [15:0] r_data [2];

  sram_dual_fifo_ctrl dut (
    .Clk_In                    (clk),
    .Reset_In                  (rst_n),
    .Ch0_Push_Data_In          (push_data[0]),
    .Ch0_Push_Valid_In         (push_valid[0]),
    .Ch0_Push_Ready_Out        (push_ready[0]),
    .Ch0_Pop_Data_Out          (pop_data[0]),
    .Ch0_Pop_Valid_Out         (pop_valid[0]),
    .Ch0_Pop_Ready_In          (pop_ready[0]),
    .Ch0_Flush_In              (flush[0]),
    .Ch0_Count_Out             (count[0]),
    .Ch1_Push_Data_In          (push_data[1]),
    .Ch1_Push_Valid_In         (push_valid[1]),
    .Ch1_Push_Ready_Out        (push_ready[1]),
    .Ch1_Pop_Data_Out          (pop_data[1]),
    .Ch1_Pop_Valid_Out         (pop_valid[1]),
    .Ch1_Pop_Ready_In          (pop_ready[1]),
    .Ch1_Flush_In              (flush[1]),
    .Ch1_Count_Out             (count[1]),
    .Sram_W_A_Data_Out         (w_data[0]),
    .Sram_W_A_Address_Out      (w_addr[0]),
    .Sram_W_A_Write_Enable_Out (w_en[0]),
    .Sram_W_B_Data_Out         (w_data[1]),
    .Sram_W_B_Address_Out      (w_addr[1]),
    .Sram_W_B_Write_Enable_Out (w_en[1]),
    .Sram_R_C_Address_Out      (r_addr[0]),
    .Sram_R_C_Read_Enable_Out  (r_en[0]),
    .Sram_R_C_Data_In          (r_data[0]),
    .Sram_R_D_Address_Out      (r_addr[1]),
    .Sram_R_D_Read_Enable_Out  (r_en[1]),
    .Sram_R_D_Data_In          (r_data[1])
  );

  // SRAM: read data only holds a real word the cycle after a read strobe.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (w_en[c]) mem[w_addr[c]] <= w_data[c];
      if (r_en[c]) r_data[c] <= mem[r_addr[c]];
      else         r_data[c] <= 16'($urandom);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a plain circular list of accepted words per channel.
  logic [15:0] mdata [2][128];
  int mhead [2];
  int msize [2];
  int wpos [2];
  int rds [2];
  int rd_cnt [2];
  int pop_cnt [2];

  initial begin
    for (int c = 0; c < 2; c++) begin
      mhead[c] = 0; msize[c] = 0; wpos[c] = 0; rds[c] = 0; rd_cnt[c] = 0; pop_cnt[c] = 0;
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        mhead[c] = 0; msize[c] = 0; wpos[c] = 0; rds[c] = 0;
      end else begin
        check("count", 32'(count[c]), 32'(msize[c]));
        check("push_ready", 32'(push_ready[c]), 32'(msize[c] != 128));
        check("w_en", 32'(w_en[c]), 32'(push_valid[c] && msize[c] != 128 && !flush[c]));
        if (w_en[c]) begin
          check("w_addr", 32'(w_addr[c]), 32'(c * 128 + wpos[c] % 128));
          check("w_data", 32'(w_data[c]), 32'(push_data[c]));
        end
        if (r_en[c]) begin
          rd_cnt[c]++;
          check("r_addr", 32'(r_addr[c]), 32'(c * 128 + rds[c] % 128));
          check("r_after_commit", 32'(rds[c] < wpos[c]), 32'd1);
          rds[c]++;
        end
        if (pop_valid[c]) check("pop_valid_nonempty", 32'(msize[c] > 0), 32'd1);
        if (pop_valid[c] && pop_ready[c] && !flush[c] && msize[c] > 0) begin
          pop_cnt[c]++;
          check("pop_data", 32'(pop_data[c]), 32'(mdata[c][mhead[c]]));
          mhead[c] = (mhead[c] + 1) % 128;
          msize[c]--;
        end
        if (flush[c]) begin
          mhead[c] = 0; msize[c] = 0; wpos[c] = 0; rds[c] = 0;
        end else if (push_valid[c] && push_ready[c] && msize[c] < 128) begin
          mdata[c][(mhead[c] + msize[c]) % 128] = push_data[c];
          msize[c]++;
          wpos[c]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int c);
    push_valid[c] = 1'b0;
    pop_ready[c]  = 1'b1;
    for (int i = 0; i < 400 && count[c] != 8'd0; i++) tick();
    tick();
    check("drain_count", 32'(count[c]), 32'd0);
    check("drain_valid", 32'(pop_valid[c]), 32'd0);
  endtask

  task automatic rand_traffic(input int c, input int n, input bit with_flush);
    for (int i = 0; i < n; i++) begin
      push_data[c]  = 16'($urandom);
      push_valid[c] = ($urandom % 4) != 0;
      pop_ready[c]  = ($urandom % 4) != 0;
      flush[c]      = with_flush && (($urandom % 64) == 0);
      tick();
    end
    flush[c] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int c = 0; c < 2; c++) begin
      push_data[c] = '0; push_valid[c] = 1'b0; pop_ready[c] = 1'b0; flush[c] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    for (int c = 0; c < 2; c++) begin
      check("rst_ready", 32'(push_ready[c]), 32'd1);
      check("rst_valid", 32'(pop_valid[c]), 32'd0);
      check("rst_count", 32'(count[c]), 32'd0);
      check("rst_wen", 32'(w_en[c]), 32'd0);
      check("rst_ren", 32'(r_en[c]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // Single word latency on channel 0
    pop_ready[0] = 1'b1;
    push_data[0] = 16'hA5A5;
    push_valid[0] = 1'b1;
    #1;
    check("lat_wen", 32'(w_en[0]), 32'd1);
    check("lat_waddr", 32'(w_addr[0]), 32'h00);
    check("lat_wdata", 32'(w_data[0]), 32'hA5A5);
    tick();
    push_valid[0] = 1'b0;
    #1;
    check("lat_ren", 32'(r_en[0]), 32'd1);
    check("lat_raddr", 32'(r_addr[0]), 32'h00);
    tick();
    check("lat_n2_valid", 32'(pop_valid[0]), 32'd0);
    tick();
    check("lat_n3_valid", 32'(pop_valid[0]), 32'd1);
    check("lat_n3_data", 32'(pop_data[0]), 32'hA5A5);
    tick();
    check("lat_popped", 32'(pop_valid[0]), 32'd0);

    // Fill channel 1 completely, then a 129th push must be ignored
    pop_ready[1] = 1'b0;
    base = rd_cnt[1];
    for (int i = 0; i < 128; i++) begin
      push_data[1] = 16'(16'h1000 + i);
      push_valid[1] = 1'b1;
      #1;
      check("fill_waddr", 32'(w_addr[1]), 32'(8'h80 + i));
      tick();
    end
    push_data[1] = 16'h1080;
    #1;
    check("full_ready", 32'(push_ready[1]), 32'd0);
    check("full_count", 32'(count[1]), 32'd128);
    check("full_no_write", 32'(w_en[1]), 32'd0);
    tick();
    check("full_reads", 32'(rd_cnt[1] - base), 32'd2);
    drain(1);

    // Backpressure on channel 0
    pop_ready[0] = 1'b0;
    base = rd_cnt[0];
    for (int i = 0; i < 10; i++) begin
      push_data[0] = 16'($urandom);
      push_valid[0] = 1'b1;
      tick();
    end
    push_valid[0] = 1'b0;
    repeat (10) tick();
    check("bp_reads", 32'(rd_cnt[0] - base), 32'd2);
    check("bp_ren", 32'(r_en[0]), 32'd0);
    check("bp_count", 32'(count[0]), 32'd10);
    drain(0);

    // Concurrent full-rate streaming on both channels, wrapping addresses
    begin
      int p0, p1;
      p0 = pop_cnt[0];
      p1 = pop_cnt[1];
      for (int i = 0; i < 300; i++) begin
        for (int c = 0; c < 2; c++) begin
          push_data[c] = 16'(c * 16'h4000 + i);
          push_valid[c] = 1'b1;
          pop_ready[c] = 1'b1;
        end
        tick();
      end
      check("thru_ch0", 32'(pop_cnt[0] - p0 >= 296), 32'd1);
      check("thru_ch1", 32'(pop_cnt[1] - p1 >= 296), 32'd1);
    end
    drain(0);
    drain(1);

    // Flush channel 1 with words queued and a read in flight; channel 0 keeps running
    fork
      rand_traffic(0, 24, 1'b0);
      begin
        pop_ready[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          push_data[1] = 16'(16'hBEE0 + i);
          push_valid[1] = 1'b1;
          tick();
        end
        push_valid[1] = 1'b0;
        repeat (4) tick();
        pop_ready[1] = 1'b1;
        tick();
        pop_ready[1] = 1'b0;
        flush[1] = 1'b1;
        tick();
        flush[1] = 1'b0;
        check("flush_count", 32'(count[1]), 32'd0);
        check("flush_valid", 32'(pop_valid[1]), 32'd0);
        pop_ready[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
          tick();
          check("flush_stale", 32'(pop_valid[1]), 32'd0);
        end
      end
    join
    drain(0);

    // Random mixed traffic with occasional flushes
    fork
      rand_traffic(0, 600, 1'b1);
      rand_traffic(1, 600, 1'b1);
    join
    drain(0);
    drain(1);

    // Asynchronous reset mid-stream
    pop_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_data[0] = 16'($urandom);
      push_valid[0] = 1'b1;
      tick();
    end
    check("pre_rst_count", 32'(count[0]), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      check("arst_count", 32'(count[c]), 32'd0);
      check("arst_ready", 32'(push_ready[c]), 32'd1);
      check("arst_valid", 32'(pop_valid[c]), 32'd0);
      check("arst_data", 32'(pop_data[c]), 32'd0);
      check("arst_wen", 32'(w_en[c]), 32'd0);
      check("arst_waddr", 32'(w_addr[c]), 32'd0);
      check("arst_wdata", 32'(w_data[c]), 32'd0);
      check("arst_ren", 32'(r_en[c]), 32'd0);
      check("arst_raddr", 32'(r_addr[c]), 32'd0);
    end
    tick();
    push_valid[0] = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_count", 32'(count[0]), 32'd0);
    check("post_rst_valid", 32'(pop_valid[0]), 32'd0);
    repeat (4) tick();
    check("post_rst_idle", 32'(pop_valid[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
